fp_exp_align_pipe: RTL and testbench



---
 rtl/fp_align_pkg.sv | 21 ++
 rtl/fp_exp_align_pipe_mag_comp.sv | 15 +
 rtl/fp_exp_align_pipe.sv | 118 +++++++++++
 tb/tb_fp_exp_align_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_align_pkg.sv
// Shared definitions for the FP adder operand-ordering stage.
// Holds the default operand geometry, the packed operand layout
// {sign, exp, mant} and the helper that sizes the alignment-shift field.
package fp_align_pkg;

  localparam int EXP_W_DEF     = 8;
  localparam int MAN_W_DEF     = 23;
  localparam int SHIFT_MAX_DEF = MAN_W_DEF + 3;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] mant;
  } fp_op_t;

  // Bits needed to hold any shift value 0..smax.
  function automatic int shift_w(input int smax);
    return $clog2(smax + 1);
  endfunction

endpackage

// File: rtl/fp_exp_align_pipe_mag_comp.sv
// mag_comp: unsigned less-than comparator of parametrised width.
// Ports:
//   a, b : W-bit unsigned operands
//   lt   : 1 when a < b
module mag_comp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt
);

  assign lt = (a < b);

endmodule

// File: rtl/fp_exp_align_pipe.sv
// fp_exp_align_pipe: two-stage elastic pipeline that orders an operand pair
// by magnitude and produces the saturated exponent-alignment shift.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_valid / o_ready             input pair handshake
//   i_data_a / i_data_b           operands {sign, exp, mant}
//   o_valid / i_ready             output handshake
//   o_swap                        a was smaller than b, operands exchanged
//   o_greater_data / o_less_data  ordered operands (signs untouched)
//   o_shift / o_shift_sat         exponent difference capped at SHIFT_MAX,
//                                 and flag for the cap being exceeded
module fp_exp_align_pipe
  import fp_align_pkg::*;
#(
  parameter int EXP_W      = EXP_W_DEF,
  parameter int MAN_W      = MAN_W_DEF,
  parameter int CMP_MANT   = 1,
  parameter int DENORM_ADJ = 1,
  parameter int SHIFT_MAX  = MAN_W + 3,
  parameter int SW         = shift_w(SHIFT_MAX)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [EXP_W+MAN_W:0]   i_data_a,
  input  logic [EXP_W+MAN_W:0]   i_data_b,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_swap,
  output logic [EXP_W+MAN_W:0]   o_greater_data,
  output logic [EXP_W+MAN_W:0]   o_less_data,
  output logic [SW-1:0]          o_shift,
  output logic                   o_shift_sat
);

  localparam int DW = 1 + EXP_W + MAN_W;
  // Compare key: {exp, mant} for full magnitude, or just exp.
  localparam int CW = (CMP_MANT != 0) ? EXP_W + MAN_W : EXP_W;

  logic             accept, s2_load, s1_move, swap_in;
  logic [CW-1:0]    key_a, key_b;
  logic [EXP_W-1:0] exp_a, exp_b, eff_a, eff_b;

  logic             s1_valid, s1_swap;
  logic [DW-1:0]    s1_g, s1_l;
  logic [EXP_W-1:0] s1_eg, s1_el;

  logic [EXP_W-1:0] diff;
  logic [31:0]      diff_w;
  logic             sat;

  // Sign bit sits above the key, so the key is the top CW bits below it.
  assign key_a = i_data_a[EXP_W+MAN_W-1 -: CW];
  assign key_b = i_data_b[EXP_W+MAN_W-1 -: CW];

  mag_comp #(.W(CW)) u_cmp (
    .a  (key_a),
    .b  (key_b),
    .lt (swap_in)
  );

  // Denormals behave as exponent 1 for alignment purposes.
  assign exp_a = i_data_a[MAN_W +: EXP_W];
  assign exp_b = i_data_b[MAN_W +: EXP_W];
  assign eff_a = (DENORM_ADJ != 0 && exp_a == '0) ? EXP_W'(1) : exp_a;
  assign eff_b = (DENORM_ADJ != 0 && exp_b == '0) ? EXP_W'(1) : exp_b;

  // Elastic control: o_ready depends combinationally on i_ready.
  assign s2_load = !o_valid || i_ready;
  assign s1_move = s1_valid && s2_load;
  assign o_ready = i_rst || !s1_valid || s1_move;
  assign accept  = i_valid && o_ready;

  // Ordering guarantees eff_greater >= eff_less, so no borrow is possible.
  assign diff   = s1_eg - s1_el;
  assign diff_w = 32'(diff);
  assign sat    = (diff_w > 32'(SHIFT_MAX));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid       <= 1'b0;
      s1_swap        <= 1'b0;
      s1_g           <= '0;
      s1_l           <= '0;
      s1_eg          <= '0;
      s1_el          <= '0;
      o_valid        <= 1'b0;
      o_swap         <= 1'b0;
      o_greater_data <= '0;
      o_less_data    <= '0;
      o_shift        <= '0;
      o_shift_sat    <= 1'b0;
    end else begin
      if (accept)       s1_valid <= 1'b1;
      else if (s1_move) s1_valid <= 1'b0;

      if (accept) begin
        s1_swap <= swap_in;
        s1_g    <= swap_in ? i_data_b : i_data_a;
        s1_l    <= swap_in ? i_data_a : i_data_b;
        s1_eg   <= swap_in ? eff_b : eff_a;
        s1_el   <= swap_in ? eff_a : eff_b;
      end

      if (s2_load) o_valid <= s1_valid;

      if (s1_move) begin
        o_swap         <= s1_swap;
        o_greater_data <= s1_g;
        o_less_data    <= s1_l;
        o_shift        <= sat ? SW'(SHIFT_MAX) : SW'(diff);
        o_shift_sat    <= sat;
      end
    end
  end

endmodule

// File: tb/tb_fp_exp_align_pipe.sv
module tb_fp_exp_align_pipe;
  import fp_align_pkg::*;

  localparam int DW = 1 + EXP_W_DEF + MAN_W_DEF;
  localparam int SW = shift_w(SHIFT_MAX_DEF);

  typedef struct {
    logic          swap;
    fp_op_t        g, l;
    logic [SW-1:0] shift;
    logic          sat;
    logic          swap_n;
    fp_op_t        g_n, l_n;
  } exp_t;

  typedef struct {
    fp_op_t        a, b;
    logic          swap;
    logic [SW-1:0] shift;
    logic          sat;
    logic          swap_n;
  } vec_t;

  logic clk, rst, in_valid, in_ready, rdy, rdy_n;
  fp_op_t data_a, data_b;
  logic out_valid, swp, sat, out_valid_n, swp_n, sat_n;
  logic [DW-1:0] g, l, g_n, l_n;
  logic [SW-1:0] shift, shift_n;

  int   n_chk = 0;
  int   fails = 0;
  bit   rnd = 0;
  exp_t cur_exp;
  exp_t sb[$];
  vec_t vecs[11];

  fp_exp_align_pipe u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy),
    .i_data_a(data_a), .i_data_b(data_b), .o_valid(out_valid), .i_ready(in_ready),
    .o_swap(swp), .o_greater_data(g), .o_less_data(l), .o_shift(shift), .o_shift_sat(sat)
  );

  fp_exp_align_pipe #(.CMP_MANT(0)) u_dut_n (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy_n),
    .i_data_a(data_a), .i_data_b(data_b), .o_valid(out_valid_n), .i_ready(in_ready),
    .o_swap(swp_n), .o_greater_data(g_n), .o_less_data(l_n), .o_shift(shift_n),
    .o_shift_sat(sat_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic fp_op_t op(input logic s, input logic [7:0] e, input logic [22:0] m);
    fp_op_t o;
    o.sign = s; o.exp = e; o.mant = m;
    return o;
  endfunction

  // Reference: ordering by magnitude, shift = |eff_a - eff_b| capped.
  function automatic exp_t model(input fp_op_t a, input fp_op_t b);
    exp_t e;
    int ea, eb, d;
    e.swap   = ({a.exp, a.mant} < {b.exp, b.mant});
    e.swap_n = (a.exp < b.exp);
    e.g   = e.swap ? b : a;    e.l   = e.swap ? a : b;
    e.g_n = e.swap_n ? b : a;  e.l_n = e.swap_n ? a : b;
    ea = (a.exp == 0) ? 1 : int'(a.exp);
    eb = (b.exp == 0) ? 1 : int'(b.exp);
    d  = (ea > eb) ? ea - eb : eb - ea;
    e.sat   = (d > SHIFT_MAX_DEF);
    e.shift = e.sat ? SW'(SHIFT_MAX_DEF) : SW'(d);
    return e;
  endfunction

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    e.swap = v.swap; e.swap_n = v.swap_n; e.shift = v.shift; e.sat = v.sat;
    e.g   = v.swap ? v.b : v.a;    e.l   = v.swap ? v.a : v.b;
    e.g_n = v.swap_n ? v.b : v.a;  e.l_n = v.swap_n ? v.a : v.b;
    return e;
  endfunction

  function automatic fp_op_t rand_op();
    fp_op_t o;
    int sel;
    o.sign = 1'($urandom);
    o.mant = 23'($urandom);
    sel = $urandom_range(0, 5);
    case (sel)
      0: o.exp = 8'h00;
      1: o.exp = 8'h01;
      2: o.exp = 8'hFE;
      default: o.exp = 8'($urandom);
    endcase
    return o;
  endfunction

  // Scoreboard: push on accept, pop on output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) sb.delete();
    else begin
      if (out_valid && in_ready) begin
        if (sb.size() == 0) begin
          n_chk++; fails++;
          $display("FAIL unexpected_output: got g=%0h with empty scoreboard", g);
        end else begin
          e = sb.pop_front();
          chk("swap", swp, e.swap);
          chk("greater", g, e.g);
          chk("less", l, e.l);
          chk("shift", shift, e.shift);
          chk("shift_sat", sat, e.sat);
          chk("n_valid", out_valid_n, 1);
          chk("n_swap", swp_n, e.swap_n);
          chk("n_greater", g_n, e.g_n);
          chk("n_less", l_n, e.l_n);
          chk("n_shift", shift_n, e.shift);
          chk("n_shift_sat", sat_n, e.sat);
        end
      end
      if (in_valid && rdy) sb.push_back(cur_exp);
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
    if (rnd) in_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  // Present a pair and hold it until accepted; returns just after the accept edge.
  task automatic send(input fp_op_t a, input fp_op_t b, input exp_t e);
    int n;
    data_a = a; data_b = b; cur_exp = e; in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!rdy && n < 100) begin cycle(); @(negedge clk); n++; end
    if (!rdy) begin
      n_chk++; fails++;
      $display("FAIL send_timeout: got o_ready=0 expected 1 within 100 cycles");
    end
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    fp_op_t bpa[4], bpb[4], a, b;
    exp_t   e0;
    int     n;

    rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1;
    data_a = '0; data_b = '0; cur_exp = model('0, '0);

    vecs[0]  = '{op(0,8'h80,0),        op(1,8'h82,1),        1, 2,  0, 1};
    vecs[1]  = '{op(0,8'h7F,23'h10),   op(0,8'h7F,23'h20),   1, 0,  0, 0};
    vecs[2]  = '{op(1,8'h7F,23'h123),  op(1,8'h7F,23'h123),  0, 0,  0, 0};
    vecs[3]  = '{op(0,8'hFE,0),        op(0,8'h01,0),        0, 26, 1, 0};
    vecs[4]  = '{op(0,8'h03,0),        op(0,8'h00,0),        0, 2,  0, 0};
    vecs[5]  = '{op(0,8'h00,5),        op(0,8'h00,9),        1, 0,  0, 0};
    vecs[6]  = '{op(0,8'h1B,0),        op(1,8'h01,7),        0, 26, 0, 0};
    vecs[7]  = '{op(0,8'h1C,0),        op(1,8'h01,7),        0, 26, 1, 0};
    vecs[8]  = '{op(0,8'h10,23'h7FFFFF), op(0,8'h40,0),      1, 26, 1, 1};
    vecs[9]  = '{op(0,8'h01,0),        op(0,8'h00,23'h7FFFFF), 0, 0, 0, 0};
    vecs[10] = '{op(1,8'h90,0),        op(0,8'h8F,23'h7FFFFF), 0, 1, 0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_o_valid", out_valid, 0);
    chk("rst_o_ready", rdy, 1);
    chk("rst_o_swap", swp, 0);
    chk("rst_o_shift", shift, 0);
    chk("rst_o_shift_sat", sat, 0);
    chk("rst_greater", g, 0);
    chk("rst_less", l, 0);
    cycle();
    rst = 1'b0;

    // Table vectors; first one also checks the 2-cycle latency
    send(vecs[0].a, vecs[0].b, from_vec(vecs[0]));
    @(negedge clk); chk("lat_c1_valid", out_valid, 0);
    cycle();
    @(negedge clk); chk("lat_c2_valid", out_valid, 1);
    cycle();
    for (int i = 1; i < 11; i++) send(vecs[i].a, vecs[i].b, from_vec(vecs[i]));
    idle(4);

    // Backpressure: two accepts fill the pipe, then hold for 5 cycles
    for (int k = 0; k < 4; k++) begin
      bpa[k] = op(1'(k), 8'(8'h80 + k), 23'(k * 3 + 1));
      bpb[k] = op(0, 8'h81, 23'(k));
    end
    in_ready = 1'b0;
    send(bpa[0], bpb[0], model(bpa[0], bpb[0]));
    send(bpa[1], bpb[1], model(bpa[1], bpb[1]));
    data_a = bpa[2]; data_b = bpb[2]; cur_exp = model(bpa[2], bpb[2]); in_valid = 1'b1;
    e0 = model(bpa[0], bpb[0]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready_low", rdy, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_greater", g, e0.g);
      chk("bp_hold_less", l, e0.l);
      chk("bp_hold_shift", shift, e0.shift);
      cycle();
    end
    in_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_no_gap", out_valid, 1);
      cycle();
      if (k == 0) begin
        data_a = bpa[3]; data_b = bpb[3]; cur_exp = model(bpa[3], bpb[3]);
      end
      if (k == 1) in_valid = 1'b0;
    end
    idle(3);

    // Reset with two pairs in flight
    in_ready = 1'b0;
    send(op(0,8'h20,1), op(0,8'h22,2), model(op(0,8'h20,1), op(0,8'h22,2)));
    send(op(1,8'h30,3), op(1,8'h10,4), model(op(1,8'h30,3), op(1,8'h10,4)));
    rst = 1'b1;
    @(negedge clk); chk("mid_rst_o_ready", rdy, 1);
    cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_o_valid", out_valid, 0);
    chk("post_rst_o_shift", shift, 0);
    in_ready = 1'b1;
    cycle();
    a = op(0,8'h05,23'h55); b = op(1,8'h09,23'h11);
    send(a, b, model(a, b));
    @(negedge clk); chk("post_rst_lat_c1", out_valid, 0);
    cycle();
    @(negedge clk); chk("post_rst_lat_c2", out_valid, 1);
    cycle();
    idle(3);
    chk("post_rst_sb_empty", sb.size(), 0);

    // Random regression with random valid gaps and random ready
    rnd = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      a = rand_op();
      n = $urandom_range(0, 7);
      if (n == 0)      b = a;
      else if (n < 3)  begin b = rand_op(); b.exp = a.exp; end
      else             b = rand_op();
      if ($urandom_range(0, 3) == 0) idle(1);
      send(a, b, model(a, b));
    end
    rnd = 1'b0;
    in_ready = 1'b1;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin cycle(); n++; end
    chk("drain_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, fails);
    $finish;
  end

endmodule
